// File: rtl/vending_machine_param.sv
// ============================================================================
// Module   : vending_machine_param
// Purpose  : Parametrised coin-operated vending controller. Accumulates
//            credit from two coin denominations, dispenses when credit
//            reaches PRICE and returns exact change as a binary amount.
//            Supports cancel/refund and same-cycle coin arbitration. An
//            optional stock counter is enabled with the STOCK_COUNT_EN
//            macro.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            coin_a       - pulse, COIN_A inserted
//            coin_b       - pulse, COIN_B inserted
//            cancel       - pulse, abort and refund credit
//            refill       - pulse, reload stock (STOCK_COUNT_EN only)
//            bottle       - one-cycle dispense pulse
//            change_valid - one-cycle pulse, change_amt valid
//            change_amt   - change/refund amount, 0 when not valid
//            credit       - current accumulated credit
//            coin_reject  - one-cycle pulse, return a sampled coin
//            sold_out     - stock exhausted (STOCK_COUNT_EN only, else 0)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_param #(
    parameter int COIN_A   = 5,
    parameter int COIN_B   = 10,
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 5,
    parameter int STOCK    = 8,
    parameter int STOCK_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                cancel,
    input  logic                refill,
    output logic                bottle,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sold_out
);

    localparam logic [CREDIT_W-1:0] C_COIN_A = CREDIT_W'(COIN_A);
    localparam logic [CREDIT_W-1:0] C_COIN_B = CREDIT_W'(COIN_B);
    localparam logic [CREDIT_W-1:0] C_PRICE  = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  bottle_q, bottle_d;
    logic                  change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]   change_amt_q, change_amt_d;
    logic                  coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0]   w_sum;
    logic                  w_enter_vend;
    logic                  w_sold_out;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        bottle_d       = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = 1'b0;
        w_sum          = credit_q;
        w_enter_vend   = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (cancel) begin
                    // Cancel wins over coins; any coin that cycle is handed back.
                    coin_reject_d = coin_a | coin_b;
                    if (credit_q != '0) begin
                        state_d        = S_REFUND;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_sold_out) begin
                    // Nothing to sell: refuse every coin and park in IDLE.
                    coin_reject_d = coin_a | coin_b;
                    state_d       = S_IDLE;
                end else begin
                    if (coin_b) begin
                        w_sum         = credit_q + C_COIN_B;
                        coin_reject_d = coin_a;
                    end else if (coin_a) begin
                        w_sum = credit_q + C_COIN_A;
                    end
                    credit_d = w_sum;
                    if (w_sum >= C_PRICE) begin
                        // Credit tops out at PRICE+COIN_B-1, so no wrap here.
                        state_d        = S_VEND;
                        w_enter_vend   = 1'b1;
                        bottle_d       = 1'b1;
                        change_valid_d = (w_sum > C_PRICE);
                        change_amt_d   = w_sum - C_PRICE;
                    end else if (w_sum != '0) begin
                        state_d = S_COLLECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                // VEND / REFUND last one cycle; coins are not credited.
                coin_reject_d = coin_a | coin_b;
                credit_d      = '0;
                state_d       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            bottle_q       <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            bottle_q       <= bottle_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

`ifdef STOCK_COUNT_EN
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               sold_out_q, sold_out_d;

    // Refill overrides a decrement landing on the same edge.
    always_comb begin
        stock_d = stock_q;
        if (refill) begin
            stock_d = STOCK_W'(STOCK);
        end else if (w_enter_vend) begin
            stock_d = stock_q - 1'b1;
        end
        sold_out_d = (stock_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stock_q    <= STOCK_W'(STOCK);
            sold_out_q <= 1'b0;
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign w_sold_out = sold_out_q;
`else
    // Unlimited stock: refill and stock parameters have no effect.
    localparam int  unused_stock_cfg = STOCK + STOCK_W;
    logic           unused_inputs;
    assign unused_inputs = refill | w_enter_vend;
    assign w_sold_out    = 1'b0;
`endif

    assign bottle       = bottle_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign sold_out     = w_sold_out;

endmodule

`default_nettype wire
